// File: rtl/hcu_pkg.sv
// Shared types for the hazard scoreboard unit: hazard cause encoding, per-stage
// control bundle and the cause-to-control mapping.
package hcu_pkg;

  localparam int unsigned HCU_NUM_REGS = 32;
  localparam int unsigned HCU_REG_AW   = 5;

  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_MEM      = 3'd1,
    HZ_BUSY     = 3'd2,
    HZ_REDIRECT = 3'd3,
    HZ_RAW      = 3'd4,
    HZ_WAW      = 3'd5
  } hz_cause_t;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic id_issue;
  } hz_ctrl_t;

  // Only the winning cause drives the pipeline; everything else stays quiet.
  function automatic hz_ctrl_t ctrl_for_cause(input hz_cause_t cause, input logic id_valid);
    hz_ctrl_t c;
    c = '0;
    case (cause)
      HZ_MEM: begin
        c.stall_if  = 1'b1;
        c.stall_id  = 1'b1;
        c.stall_ex  = 1'b1;
        c.stall_mem = 1'b1;
      end
      HZ_BUSY: begin
        c.stall_if     = 1'b1;
        c.stall_id     = 1'b1;
        c.stall_ex     = 1'b1;
        c.flush_ex_mem = 1'b1;
      end
      HZ_REDIRECT: begin
        c.flush_if_id = 1'b1;
        c.flush_id_ex = 1'b1;
      end
      HZ_RAW, HZ_WAW: begin
        c.stall_if    = 1'b1;
        c.stall_id    = 1'b1;
        c.flush_id_ex = 1'b1;
      end
      default: c.id_issue = id_valid;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hcu_scoreboard.sv
// Per-register pending-write bits with set/clear update and done-bypassed
// lookups for the ID stage's rs1, rs2 and rd.
module hcu_scoreboard
  import hcu_pkg::*;
#(
  parameter int unsigned NUM_REGS = HCU_NUM_REGS,
  parameter int unsigned REG_AW   = HCU_REG_AW
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                set_valid_i,
  input  logic [REG_AW-1:0]   set_addr_i,
  input  logic                clr_valid_i,
  input  logic [REG_AW-1:0]   clr_addr_i,
  input  logic [REG_AW-1:0]   rs1_addr_i,
  input  logic [REG_AW-1:0]   rs2_addr_i,
  input  logic [REG_AW-1:0]   rd_addr_i,
  output logic                rs1_pend_o,
  output logic                rs2_pend_o,
  output logic                rd_pend_o,
  output logic [NUM_REGS-1:0] pending_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] live;

  function automatic logic pick(input logic [NUM_REGS-1:0] vec, input logic [REG_AW-1:0] addr);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == REG_AW'(i)) r = vec[i];
    end
    return r;
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    pending_d = '0;
    live      = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      // A result completing this cycle is already forwardable, so hide its bit.
      live[i] = pending_q[i] & ~(clr_valid_i & (clr_addr_i == REG_AW'(i)));
      if (set_valid_i && set_addr_i == REG_AW'(i)) begin
        pending_d[i] = 1'b1;
      end else if (clr_valid_i && clr_addr_i == REG_AW'(i)) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  // NOTE: these bits are plain flops, not a RAM, and must be reset: a reset
  // kills every in-flight producer, so no write may stay pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign rs1_pend_o = pick(live, rs1_addr_i);
  assign rs2_pend_o = pick(live, rs2_addr_i);
  assign rd_pend_o  = pick(live, rd_addr_i);
  assign pending_o  = pending_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: prioritised stall/flush/issue
// control, pending-write scoreboard, stall watchdog; HCU_PERF_CNT_EN adds perf counters.
module hazard_scoreboard_unit
  import hcu_pkg::*;
#(
  parameter int unsigned NUM_REGS      = HCU_NUM_REGS,
  parameter int unsigned REG_AW        = HCU_REG_AW,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                id_valid_i,
  input  logic [REG_AW-1:0]   id_rs1_addr_i,
  input  logic [REG_AW-1:0]   id_rs2_addr_i,
  input  logic                id_rs1_used_i,
  input  logic                id_rs2_used_i,
  input  logic [REG_AW-1:0]   id_rd_addr_i,
  input  logic                id_rd_we_i,
  input  logic                id_long_lat_i,
  input  logic                ex_take_b_j_i,
  input  logic                ex_busy_i,
  input  logic                mem_stall_i,
  input  logic                done_valid_i,
  input  logic [REG_AW-1:0]   done_rd_addr_i,
  input  logic                perf_clr_i,
  output logic                stall_if_o,
  output logic                stall_id_o,
  output logic                stall_ex_o,
  output logic                stall_mem_o,
  output logic                flush_if_id_o,
  output logic                flush_id_ex_o,
  output logic                flush_ex_mem_o,
  output logic                id_issue_o,
  output logic [2:0]          hz_cause_o,
  output logic [NUM_REGS-1:0] sb_pending_o,
  output logic                deadlock_o,
  output logic [CNT_W-1:0]    perf_raw_stall_cnt_o,
  output logic [CNT_W-1:0]    perf_mem_stall_cnt_o,
  output logic [CNT_W-1:0]    perf_redirect_cnt_o
);

  localparam int unsigned    WD_W   = $clog2(STALL_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

  logic      rs1_pend, rs2_pend, rd_pend;
  logic      raw_hit, waw_hit, sb_set;
  hz_cause_t cause;
  hz_ctrl_t  ctrl;

  hcu_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .set_valid_i (sb_set),
    .set_addr_i  (id_rd_addr_i),
    .clr_valid_i (done_valid_i),
    .clr_addr_i  (done_rd_addr_i),
    .rs1_addr_i  (id_rs1_addr_i),
    .rs2_addr_i  (id_rs2_addr_i),
    .rd_addr_i   (id_rd_addr_i),
    .rs1_pend_o  (rs1_pend),
    .rs2_pend_o  (rs2_pend),
    .rd_pend_o   (rd_pend),
    .pending_o   (sb_pending_o)
  );

  always_comb begin
    raw_hit = id_valid_i & ((id_rs1_used_i & rs1_pend) | (id_rs2_used_i & rs2_pend));
    waw_hit = id_valid_i & id_long_lat_i & id_rd_we_i & rd_pend;
    if (mem_stall_i)        cause = HZ_MEM;
    else if (ex_busy_i)     cause = HZ_BUSY;
    else if (ex_take_b_j_i) cause = HZ_REDIRECT;
    else if (raw_hit)       cause = HZ_RAW;
    else if (waw_hit)       cause = HZ_WAW;
    else                    cause = HZ_NONE;
    ctrl   = ctrl_for_cause(cause, id_valid_i);
    // Issue excludes every flush, so flushed instructions never mark a register.
    sb_set = ctrl.id_issue & id_long_lat_i & id_rd_we_i & (id_rd_addr_i != '0);
  end

  // Control outputs are held low for the whole time reset is asserted.
  assign stall_if_o     = rst_ni & ctrl.stall_if;
  assign stall_id_o     = rst_ni & ctrl.stall_id;
  assign stall_ex_o     = rst_ni & ctrl.stall_ex;
  assign stall_mem_o    = rst_ni & ctrl.stall_mem;
  assign flush_if_id_o  = rst_ni & ctrl.flush_if_id;
  assign flush_id_ex_o  = rst_ni & ctrl.flush_id_ex;
  assign flush_ex_mem_o = rst_ni & ctrl.flush_ex_mem;
  assign id_issue_o     = rst_ni & ctrl.id_issue;
  assign hz_cause_o     = rst_ni ? cause : HZ_NONE;

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            deadlock_q, deadlock_d;

  always_comb begin
    wd_cnt_d = '0;
    if (ctrl.stall_if) begin
      wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
    end
    deadlock_d = deadlock_q | (wd_cnt_d == WD_MAX);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q   <= '0;
      deadlock_q <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      deadlock_q <= deadlock_d;
    end
  end

  assign deadlock_o = deadlock_q;

`ifdef HCU_PERF_CNT_EN
  logic [CNT_W-1:0] raw_cnt_q, raw_cnt_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [CNT_W-1:0] red_cnt_q, red_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    raw_cnt_d = '0;
    mem_cnt_d = '0;
    red_cnt_d = '0;
    if (!perf_clr_i) begin
      raw_cnt_d = sat_inc(raw_cnt_q, (cause == HZ_RAW) || (cause == HZ_WAW));
      mem_cnt_d = sat_inc(mem_cnt_q, cause == HZ_MEM);
      red_cnt_d = sat_inc(red_cnt_q, cause == HZ_REDIRECT);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      raw_cnt_q <= '0;
      mem_cnt_q <= '0;
      red_cnt_q <= '0;
    end else begin
      raw_cnt_q <= raw_cnt_d;
      mem_cnt_q <= mem_cnt_d;
      red_cnt_q <= red_cnt_d;
    end
  end

  assign perf_raw_stall_cnt_o = raw_cnt_q;
  assign perf_mem_stall_cnt_o = mem_cnt_q;
  assign perf_redirect_cnt_o  = red_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr      = perf_clr_i;
  assign perf_raw_stall_cnt_o = '0;
  assign perf_mem_stall_cnt_o = '0;
  assign perf_redirect_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed + randomized bench for hazard_scoreboard_unit, checked against a
// behavioural model of the priority rules, scoreboard and watchdog.
module tb_hazard_scoreboard_unit;
  import hcu_pkg::*;

  localparam int TO   = 16;
  localparam int CW   = 32;
  localparam longint MAXC = (longint'(1) << CW) - 1;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        id_valid_i, id_rs1_used_i, id_rs2_used_i, id_rd_we_i, id_long_lat_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, done_rd_addr_i;
  logic        ex_take_b_j_i, ex_busy_i, mem_stall_i, done_valid_i, perf_clr_i;
  logic        stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
  logic        flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, id_issue_o;
  logic [2:0]  hz_cause_o;
  logic [31:0] sb_pending_o;
  logic        deadlock_o;
  logic [CW-1:0] perf_raw_stall_cnt_o, perf_mem_stall_cnt_o, perf_redirect_cnt_o;

  always #5 clk_i = ~clk_i;

  hazard_scoreboard_unit #(
    .NUM_REGS      (32),
    .REG_AW        (5),
    .STALL_TIMEOUT (TO),
    .CNT_W         (CW)
  ) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .id_valid_i           (id_valid_i),
    .id_rs1_addr_i        (id_rs1_addr_i),
    .id_rs2_addr_i        (id_rs2_addr_i),
    .id_rs1_used_i        (id_rs1_used_i),
    .id_rs2_used_i        (id_rs2_used_i),
    .id_rd_addr_i         (id_rd_addr_i),
    .id_rd_we_i           (id_rd_we_i),
    .id_long_lat_i        (id_long_lat_i),
    .ex_take_b_j_i        (ex_take_b_j_i),
    .ex_busy_i            (ex_busy_i),
    .mem_stall_i          (mem_stall_i),
    .done_valid_i         (done_valid_i),
    .done_rd_addr_i       (done_rd_addr_i),
    .perf_clr_i           (perf_clr_i),
    .stall_if_o           (stall_if_o),
    .stall_id_o           (stall_id_o),
    .stall_ex_o           (stall_ex_o),
    .stall_mem_o          (stall_mem_o),
    .flush_if_id_o        (flush_if_id_o),
    .flush_id_ex_o        (flush_id_ex_o),
    .flush_ex_mem_o       (flush_ex_mem_o),
    .id_issue_o           (id_issue_o),
    .hz_cause_o           (hz_cause_o),
    .sb_pending_o         (sb_pending_o),
    .deadlock_o           (deadlock_o),
    .perf_raw_stall_cnt_o (perf_raw_stall_cnt_o),
    .perf_mem_stall_cnt_o (perf_mem_stall_cnt_o),
    .perf_redirect_cnt_o  (perf_redirect_cnt_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: which registers await a long-latency result, stall run length.
  bit [31:0] m_pend;
  int        m_wd;
  bit        m_dead;
  longint    m_raw, m_mem, m_red;
  int        m_cause;
  bit        m_issue, m_stall_if;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint perf_exp(input longint v);
`ifdef HCU_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic bit live(input int a);
    return (a != 0) && m_pend[a] && !(done_valid_i && int'(done_rd_addr_i) == a);
  endfunction

  task automatic idle();
    id_valid_i = 0; id_rs1_used_i = 0; id_rs2_used_i = 0; id_rd_we_i = 0; id_long_lat_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rd_addr_i = 0; done_rd_addr_i = 0;
    ex_take_b_j_i = 0; ex_busy_i = 0; mem_stall_i = 0; done_valid_i = 0; perf_clr_i = 0;
  endtask

  task automatic cmp_model(input string tag);
    bit raw, waw;
    bit [7:0] e;  // {stall if,id,ex,mem, flush if_id,id_ex,ex_mem, issue}
    raw = id_valid_i && ((id_rs1_used_i && live(int'(id_rs1_addr_i))) ||
                         (id_rs2_used_i && live(int'(id_rs2_addr_i))));
    waw = id_valid_i && id_long_lat_i && id_rd_we_i && live(int'(id_rd_addr_i));
    if (mem_stall_i)        m_cause = 1;
    else if (ex_busy_i)     m_cause = 2;
    else if (ex_take_b_j_i) m_cause = 3;
    else if (raw)           m_cause = 4;
    else if (waw)           m_cause = 5;
    else                    m_cause = 0;
    case (m_cause)
      1:       e = 8'b1111_0000;
      2:       e = 8'b1110_0010;
      3:       e = 8'b0000_1100;
      4, 5:    e = 8'b1100_0100;
      default: e = {7'b0, id_valid_i};
    endcase
    m_issue    = e[0];
    m_stall_if = e[7];
    check({tag, "_cause"}, hz_cause_o, m_cause);
    check({tag, "_ctrl"}, {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
                           flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, id_issue_o}, e);
    check({tag, "_pend"}, sb_pending_o, m_pend);
    check({tag, "_dead"}, deadlock_o, m_dead);
    check({tag, "_praw"}, perf_raw_stall_cnt_o, perf_exp(m_raw));
    check({tag, "_pmem"}, perf_mem_stall_cnt_o, perf_exp(m_mem));
    check({tag, "_pred"}, perf_redirect_cnt_o, perf_exp(m_red));
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (done_valid_i) m_pend[done_rd_addr_i] = 1'b0;
    if (m_issue && id_long_lat_i && id_rd_we_i && id_rd_addr_i != 0) m_pend[id_rd_addr_i] = 1'b1;
    m_pend[0] = 1'b0;
    m_wd = m_stall_if ? ((m_wd < TO) ? m_wd + 1 : TO) : 0;
    if (m_wd == TO) m_dead = 1'b1;
    if (perf_clr_i) begin
      m_raw = 0; m_mem = 0; m_red = 0;
    end else begin
      if ((m_cause == 4 || m_cause == 5) && m_raw < MAXC) m_raw++;
      if (m_cause == 1 && m_mem < MAXC) m_mem++;
      if (m_cause == 3 && m_red < MAXC) m_red++;
    end
    @(negedge clk_i);
  endtask

  task automatic step(input string tag, input int exp_cause = -1);
    #1;
    if (exp_cause >= 0) check({tag, "_cause_const"}, hz_cause_o, exp_cause);
    cmp_model(tag);
    tick();
  endtask

  task automatic do_reset(input string tag);
    rst_ni = 1'b0;
    #1;
    check({tag, "_ctrl"}, {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
                           flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, id_issue_o}, 0);
    check({tag, "_cause"}, hz_cause_o, 0);
    check({tag, "_pend"}, sb_pending_o, 0);
    check({tag, "_dead"}, deadlock_o, 0);
    check({tag, "_perf"}, {perf_raw_stall_cnt_o, perf_mem_stall_cnt_o} | perf_redirect_cnt_o, 0);
    m_pend = 0; m_wd = 0; m_dead = 0; m_raw = 0; m_mem = 0; m_red = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic load(input logic [4:0] rd);
    idle();
    id_valid_i = 1; id_rd_addr_i = rd; id_rd_we_i = 1; id_long_lat_i = 1;
  endtask

  initial begin
    idle();
    rst_ni = 1'b0;
    m_pend = 0; m_wd = 0; m_dead = 0; m_raw = 0; m_mem = 0; m_red = 0;
    @(negedge clk_i);
    mem_stall_i = 1; id_valid_i = 1;
    do_reset("rst0");

    // Load-use: load x5, then add x6,x5,x1 stalls once and issues via the done bypass.
    load(5); step("lu_load", 0);
    idle(); id_valid_i = 1; id_rs1_addr_i = 5; id_rs1_used_i = 1; id_rs2_addr_i = 1;
    id_rs2_used_i = 1; id_rd_addr_i = 6; id_rd_we_i = 1;
    step("lu_stall", 4);
    done_valid_i = 1; done_rd_addr_i = 5;
    step("lu_bypass", 0);
    check("lu_pend_after", sb_pending_o, 0);

    // Load held by a DMEM stall.
    load(5); step("ms_load", 0);
    idle(); mem_stall_i = 1; id_valid_i = 1; id_rs1_addr_i = 3; id_rs1_used_i = 1;
    for (int i = 0; i < 3; i++) begin
      step("ms_stall", 1);
      check("ms_pend5", sb_pending_o[5], 1);
    end
    idle(); done_valid_i = 1; done_rd_addr_i = 5;
    step("ms_done", 0);
    check("ms_pend5_clr", sb_pending_o[5], 0);

    // Taken branch under a memory stall redirects exactly once on release.
    idle(); ex_take_b_j_i = 1; mem_stall_i = 1; id_valid_i = 1;
    step("br_mem0", 1);
    step("br_mem1", 1);
    mem_stall_i = 0;
    step("br_redir", 3);
    idle(); id_valid_i = 1;
    step("br_after", 0);

    // Busy outranks redirect.
    idle(); ex_busy_i = 1; ex_take_b_j_i = 1; id_valid_i = 1;
    step("busy", 2);

    // x0 is never tracked.
    load(0); step("x0_load", 0);
    check("x0_pend", sb_pending_o, 0);
    idle(); id_valid_i = 1; id_rs1_used_i = 1; id_rs2_used_i = 1;
    step("x0_use", 0);

    // Back-to-back loads to x7: WAW until done, then same-cycle set beats clear.
    load(7); step("waw_first", 0);
    step("waw_stall0", 5);
    step("waw_stall1", 5);
    done_valid_i = 1; done_rd_addr_i = 7;
    step("waw_issue", 0);
    check("waw_set_wins", sb_pending_o[7], 1);
    idle(); done_valid_i = 1; done_rd_addr_i = 7;
    step("waw_drain", 0);
    check("waw_pend7_clr", sb_pending_o[7], 0);

    // Watchdog: 16 consecutive stall cycles raise the sticky flag.
    idle(); mem_stall_i = 1;
    for (int i = 0; i < TO - 1; i++) step("wd_run", 1);
    check("wd_not_yet", deadlock_o, 0);
    step("wd_last", 1);
    check("wd_raised", deadlock_o, 1);
    idle();
    for (int i = 0; i < 3; i++) step("wd_hold", 0);
    check("wd_sticky", deadlock_o, 1);
    perf_clr_i = 1;
    step("perf_clr", 0);
    perf_clr_i = 0;
    check("perf_mem_cleared", perf_mem_stall_cnt_o, 0);
    mem_stall_i = 1;
    step("perf_after_clr", 1);
    check("perf_mem_one", perf_mem_stall_cnt_o, perf_exp(1));
    idle();
    do_reset("wd_rst");

    // Reset in the middle of a RAW stall drops the pending bit.
    load(9); step("rm_load", 0);
    idle(); id_valid_i = 1; id_rs2_addr_i = 9; id_rs2_used_i = 1;
    step("rm_stall", 4);
    do_reset("rm_rst");
    step("rm_post", 0);
    check("rm_pend_clr", sb_pending_o, 0);

    // Randomized traffic on a small register window to provoke frequent hazards.
    for (int n = 0; n < 600; n++) begin
      id_valid_i     = $urandom_range(0, 3) != 0;
      id_rs1_addr_i  = 5'($urandom_range(0, 7));
      id_rs2_addr_i  = 5'($urandom_range(0, 7));
      id_rd_addr_i   = 5'($urandom_range(0, 7));
      id_rs1_used_i  = $urandom_range(0, 1) == 1;
      id_rs2_used_i  = $urandom_range(0, 1) == 1;
      id_rd_we_i     = $urandom_range(0, 3) != 0;
      id_long_lat_i  = $urandom_range(0, 1) == 1;
      mem_stall_i    = $urandom_range(0, 9) == 0;
      ex_busy_i      = $urandom_range(0, 11) == 0;
      ex_take_b_j_i  = $urandom_range(0, 7) == 0;
      done_valid_i   = $urandom_range(0, 2) == 0;
      done_rd_addr_i = 5'($urandom_range(0, 7));
      perf_clr_i     = $urandom_range(0, 63) == 0;
      step("rnd");
      if (n == 300) begin
        idle();
        do_reset("rnd_rst");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised hazard controller for the 5-stage RV32I pipeline. It supersedes pure load-use detection with a per-register pending-write scoreboard that covers variable-latency producers: loads behind a stalling DMEM, and multi-cycle EX units such as a future M-extension divider. It arbitrates memory stalls, EX-busy stalls, taken-branch redirects and RAW/WAW hazards into per-stage stall, flush and issue controls. It also contains a stall watchdog and optional performance counters.

## Interface
- NUM_REGS, 32: architectural registers; x0 is never tracked.
- REG_AW, 5: register address width, $clog2(NUM_REGS).
- STALL_TIMEOUT, 1024: consecutive stall_if_o cycles before deadlock_o asserts.
- CNT_W, 32: perf counter width.

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- id_valid_i  in  1  IF/ID holds a valid instruction
- id_rs1_addr_i / id_rs2_addr_i  in  REG_AW  ID source registers
- id_rs1_used_i / id_rs2_used_i  in  1  the source is actually read
- id_rd_addr_i  in  REG_AW  ID destination
- id_rd_we_i  in  1  ID writes rd
- id_long_lat_i  in  1  ID instruction is a long-latency producer (load, multi-cycle op)
- ex_take_b_j_i  in  1  EX resolves a taken branch or jump
- ex_busy_i  in  1  multi-cycle EX unit has not finished
- mem_stall_i  in  1  DMEM not ready; freeze the pipeline
- done_valid_i  in  1  long-latency result becomes forwardable next cycle
- done_rd_addr_i  in  REG_AW  destination of that result
- perf_clr_i  in  1  synchronous clear of the perf counters
- stall_if_o, stall_id_o, stall_ex_o, stall_mem_o  out  1  hold the stage register
- flush_if_id_o, flush_id_ex_o, flush_ex_mem_o  out  1  insert a bubble
- id_issue_o  out  1  ID instruction advances into EX this cycle
- hz_cause_o  out  3  hz_cause_t of the winning cause
- sb_pending_o  out  NUM_REGS  scoreboard bits; bit 0 is always 0
- deadlock_o  out  1  sticky watchdog flag
- perf_raw_stall_cnt_o, perf_mem_stall_cnt_o, perf_redirect_cnt_o  out  CNT_W  perf counters

## Operation
- Causes are evaluated combinationally each cycle. Only the highest-priority cause acts, in this order: MEM > BUSY > REDIRECT > RAW > WAW > NONE.
- MEM (mem_stall_i):
  - all four stall outputs are 1, flushes are 0, id_issue_o is 0.
  - A taken branch held in EX is re-evaluated once the stall releases, so exactly one redirect occurs.
- BUSY (ex_busy_i):
  - stall_if_o, stall_id_o and stall_ex_o are 1; flush_ex_mem_o is 1.
  - ex_take_b_j_i is ignored.
- REDIRECT (ex_take_b_j_i): flush_if_id_o and flush_id_ex_o are 1, no stalls, id_issue_o is 0.
- RAW: id_valid_i, and a used source (non-zero) has its pending bit set, and that bit is not being cleared by done_valid_i/done_rd_addr_i this cycle (done bypass). Response: stall_if_o, stall_id_o and flush_id_ex_o are 1.
- WAW: id_valid_i & id_long_lat_i & id_rd_we_i & rd != 0, and pending[rd] is set and not bypassed. Same response as RAW.
- NONE: id_issue_o = id_valid_i; all other outputs are 0.
- Scoreboard update, registered:
  - set pending[rd] on id_issue_o & id_long_lat_i & id_rd_we_i & rd != 0;
  - clear pending[done_rd] on done_valid_i;
  - if set and clear target the same register in the same cycle, set wins.
- Flushes never touch the scoreboard. Only issued instructions set bits, and issue is mutually exclusive with every flush.
- Watchdog:
  - counter increments while stall_if_o is 1 and clears otherwise; it saturates at STALL_TIMEOUT;
  - deadlock_o sets when the count reaches STALL_TIMEOUT and stays set until reset.

## Timing
- Stall, flush, issue and cause outputs are combinational from inputs and state, valid in the same cycle.
- Scoreboard changes are visible on sb_pending_o the cycle after the edge.
- Load-use penalty is 1 cycle:
  - load issues at t and reaches MEM at t+2 with done_valid_i;
  - consumer stalls at t+1 and issues at t+2 via the bypass.
- Reset (async assert, sync-safe release):
  - pending is 0, watchdog is 0, deadlock_o is 0, counters are 0;
  - while rst_ni is low, every output is 0.
- Reset mid-stall drops all pending bits. The pipeline is flushed by its own reset.

## Configuration
- HCU_PERF_CNT_EN defined: three saturating CNT_W counters.
  - raw: RAW+WAW cycles.
  - mem: MEM cycles.
  - redirect: REDIRECT cycles.
  - perf_clr_i zeroes all three; clear wins over increment.
- HCU_PERF_CNT_EN undefined: no counter flops; the perf outputs are tied to 0.

## Structure
- Package hcu_pkg holds:
  - hz_cause_t enum: HZ_NONE=0, HZ_MEM=1, HZ_BUSY=2, HZ_REDIRECT=3, HZ_RAW=4, HZ_WAW=5;
  - default REG_AW.
- Sub-module hcu_scoreboard holds the pending-bit array, set/clear logic and the bypassed lookup ports (rs1, rs2, rd).

## Test plan
- Load x5 issues at t; ID `add x6,x5,x1` at t+1 -> RAW stall only at t+1 (hz_cause_o=4); done_valid_i with rd=5 at t+2 -> id_issue_o=1 at t+2.
- Load x5 with mem_stall_i high for 3 cycles -> all stalls high for those 3 cycles, hz_cause_o=1, pending[5] held until done.
- ex_take_b_j_i with mem_stall_i -> no flush; mem_stall_i drops -> flush_if_id_o and flush_id_ex_o for exactly 1 cycle.
- Load to x0 followed by a use of x0 -> no pending bit set, no stall.
- Two loads to x7 back to back -> second gets WAW stall (cause 5) until done rd=7; same-cycle done rd=7 and issue rd=7 -> pending[7] stays 1.
- Force stall_if_o for STALL_TIMEOUT=16 cycles -> deadlock_o rises on the 16th cycle and holds; rst_ni low clears it. With HCU_PERF_CNT_EN, perf_mem_stall_cnt_o equals the mem-stall cycles and perf_clr_i zeroes it.
